cpu_trace_emitter: RTL and testbench

Serialises CPU write-back records into the ASCII trace character stream that the CPU output format checker consumes, one character per clock. Each accepted record becomes one register frame `^<time>@<pc>: $<reg> <= <data>#` or one memory frame `^<time>@<pc>: *<addr> <= <data>#`. The `char` output connects directly to the checker's `char` input, so every frame the emitter produces must be accepted by the checker.

---
 rtl/cpu_trace_emitter_if.sv | 39 +++
 rtl/cpu_trace_emitter.sv | 252 +++++++++++++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_emitter_if.sv
// cpu_trace_emitter_if
// Record handshake between a CPU write-back source and the trace emitter.
//   in_valid  : a record is presented on the in_* fields
//   in_ready  : emitter can accept a record this cycle
//   in_is_reg : 1 = register frame ('$'), 0 = memory frame ('*')
//   in_time   : time stamp (decimal, saturates at 9999)
//   in_pc     : program counter (8 hex digits)
//   in_addr   : register number in [4:0] or 32-bit memory address
//   in_data   : written value (8 hex digits)
// master = record source, slave = emitter.
interface cpu_trace_emitter_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_reg;
   logic [15:0] in_time;
   logic [31:0] in_pc;
   logic [31:0] in_addr;
   logic [31:0] in_data;

   modport master (
      output in_valid,
      output in_is_reg,
      output in_time,
      output in_pc,
      output in_addr,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_is_reg,
      input  in_time,
      input  in_pc,
      input  in_addr,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter
// Serialises CPU write-back records into the ASCII trace stream, one character per clock:
//   register frame: ^<time>@<pc>: $<reg> <= <data>#
//   memory frame  : ^<time>@<pc>: *<addr> <= <data>#
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   rec        : record handshake (slave modport of cpu_trace_emitter_if)
//   char       : current frame character, 8'h00 when idle (registered)
//   char_valid : char holds a frame character (registered)
module cpu_trace_emitter (
   input  logic                clk,
   input  logic                reset,
   cpu_trace_emitter_if.slave  rec,
   output logic [7:0]          char,
   output logic                char_valid
);

   typedef enum logic [3:0] {
      StIdle, StStart, StTime, StAt, StPc, StColon, StSp0, StKind,
      StAddr, StSp1, StLt, StEq, StSp2, StData, StEnd
   } state_e;

   state_e      state_q;
   logic [2:0]  idx_q;
   logic        is_reg_q;
   logic [15:0] time_bcd_q;   // left-aligned: first printed digit in [15:12]
   logic [2:0]  time_n_q;     // number of time digits, 1..4
   logic [7:0]  reg_bcd_q;    // left-aligned: first printed digit in [7:4]
   logic [2:0]  reg_n_q;      // number of register digits, 1..2
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;

   logic        hs;
   logic [2:0]  idx_nx;
   logic        addr_last;

   // Capture-time conversions
   logic [13:0] time_sat;
   logic [15:0] time_bcd;
   logic [15:0] cap_time_bcd;
   logic [2:0]  cap_time_n;
   logic [1:0]  reg_tens;
   logic [3:0]  reg_sub;
   logic [3:0]  reg_ones;
   logic [7:0]  cap_reg_bcd;
   logic [2:0]  cap_reg_n;

   function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
      logic [29:0] sh;
      sh = {16'd0, bin};
      for (int i = 0; i < 14; i++) begin
         for (int d = 0; d < 4; d++) begin
            if (sh[14 + 4 * d +: 4] >= 4'd5) begin
               sh[14 + 4 * d +: 4] = sh[14 + 4 * d +: 4] + 4'd3;
            end
         end
         sh = sh << 1;
      end
      return sh[29:14];
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   function automatic logic [7:0] dec_char(input logic [3:0] d);
      return 8'h30 + {4'h0, d};
   endfunction

   // Nibble i of w, most-significant first
   function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] i);
      return w[{~i, 2'b00} +: 4];
   endfunction

   assign rec.in_ready = (state_q == StIdle) || (state_q == StEnd);
   assign hs           = rec.in_valid && rec.in_ready;
   assign idx_nx       = idx_q + 3'd1;
   assign addr_last    = is_reg_q ? (idx_q == reg_n_q - 3'd1) : (idx_q == 3'd7);

   always_comb begin
      time_sat = (rec.in_time > 16'd9999) ? 14'd9999 : rec.in_time[13:0];
      time_bcd = bin2bcd(time_sat);
      // Strip leading zeros by left-aligning the significant digits
      if (time_bcd[15:12] != 4'd0) begin
         cap_time_n   = 3'd4;
         cap_time_bcd = time_bcd;
      end else if (time_bcd[11:8] != 4'd0) begin
         cap_time_n   = 3'd3;
         cap_time_bcd = {time_bcd[11:0], 4'h0};
      end else if (time_bcd[7:4] != 4'd0) begin
         cap_time_n   = 3'd2;
         cap_time_bcd = {time_bcd[7:0], 8'h00};
      end else begin
         cap_time_n   = 3'd1;
         cap_time_bcd = {time_bcd[3:0], 12'h000};
      end

      // reg_sub is (tens * 10) mod 16, so a 4-bit subtract of the low nibble yields the ones digit
      if (rec.in_addr[4:0] >= 5'd30) begin
         reg_tens = 2'd3;
         reg_sub  = 4'd14;
      end else if (rec.in_addr[4:0] >= 5'd20) begin
         reg_tens = 2'd2;
         reg_sub  = 4'd4;
      end else if (rec.in_addr[4:0] >= 5'd10) begin
         reg_tens = 2'd1;
         reg_sub  = 4'd10;
      end else begin
         reg_tens = 2'd0;
         reg_sub  = 4'd0;
      end
      reg_ones = rec.in_addr[3:0] - reg_sub;
      if (reg_tens != 2'd0) begin
         cap_reg_n   = 3'd2;
         cap_reg_bcd = {2'b00, reg_tens, reg_ones};
      end else begin
         cap_reg_n   = 3'd1;
         cap_reg_bcd = {reg_ones, 4'h0};
      end
   end

   // Each transition loads the character belonging to the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         idx_q      <= 3'd0;
         char       <= 8'h00;
         char_valid <= 1'b0;
         is_reg_q   <= 1'b0;
         time_bcd_q <= 16'h0000;
         time_n_q   <= 3'd1;
         reg_bcd_q  <= 8'h00;
         reg_n_q    <= 3'd1;
         pc_q       <= 32'h0;
         addr_q     <= 32'h0;
         data_q     <= 32'h0;
      end else begin
         case (state_q)
            StIdle, StEnd: begin
               idx_q <= 3'd0;
               if (hs) begin
                  is_reg_q   <= rec.in_is_reg;
                  time_bcd_q <= cap_time_bcd;
                  time_n_q   <= cap_time_n;
                  reg_bcd_q  <= cap_reg_bcd;
                  reg_n_q    <= cap_reg_n;
                  pc_q       <= rec.in_pc;
                  addr_q     <= rec.in_addr;
                  data_q     <= rec.in_data;
                  state_q    <= StStart;
                  char       <= "^";
                  char_valid <= 1'b1;
               end else begin
                  state_q    <= StIdle;
                  char       <= 8'h00;
                  char_valid <= 1'b0;
               end
            end
            StStart: begin
               state_q <= StTime;
               idx_q   <= 3'd0;
               char    <= dec_char(time_bcd_q[15:12]);
            end
            StTime: begin
               if (idx_q == time_n_q - 3'd1) begin
                  state_q <= StAt;
                  idx_q   <= 3'd0;
                  char    <= "@";
               end else begin
                  idx_q <= idx_nx;
                  char  <= dec_char(time_bcd_q[{~idx_nx[1:0], 2'b00} +: 4]);
               end
            end
            StAt: begin
               state_q <= StPc;
               idx_q   <= 3'd0;
               char    <= hex_char(pc_q[31:28]);
            end
            StPc: begin
               if (idx_q == 3'd7) begin
                  state_q <= StColon;
                  idx_q   <= 3'd0;
                  char    <= ":";
               end else begin
                  idx_q <= idx_nx;
                  char  <= hex_char(nib(pc_q, idx_nx));
               end
            end
            StColon: begin
               state_q <= StSp0;
               char    <= " ";
            end
            StSp0: begin
               state_q <= StKind;
               char    <= is_reg_q ? "$" : "*";
            end
            StKind: begin
               state_q <= StAddr;
               idx_q   <= 3'd0;
               char    <= is_reg_q ? dec_char(reg_bcd_q[7:4]) : hex_char(addr_q[31:28]);
            end
            StAddr: begin
               if (addr_last) begin
                  state_q <= StSp1;
                  idx_q   <= 3'd0;
                  char    <= " ";
               end else begin
                  idx_q <= idx_nx;
                  char  <= is_reg_q ? dec_char(reg_bcd_q[{~idx_nx[0], 2'b00} +: 4])
                                    : hex_char(nib(addr_q, idx_nx));
               end
            end
            StSp1: begin
               state_q <= StLt;
               char    <= "<";
            end
            StLt: begin
               state_q <= StEq;
               char    <= "=";
            end
            StEq: begin
               state_q <= StSp2;
               char    <= " ";
            end
            StSp2: begin
               state_q <= StData;
               idx_q   <= 3'd0;
               char    <= hex_char(data_q[31:28]);
            end
            StData: begin
               if (idx_q == 3'd7) begin
                  state_q <= StEnd;
                  idx_q   <= 3'd0;
                  char    <= "#";
               end else begin
                  idx_q <= idx_nx;
                  char  <= hex_char(nib(data_q, idx_nx));
               end
            end
            default: begin
               state_q    <= StIdle;
               idx_q      <= 3'd0;
               char       <= 8'h00;
               char_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: expected frames are hand-written strings.
module tb_cpu_trace_emitter;

   logic       clk;
   logic       reset;
   logic [7:0] ch;
   logic       ch_valid;

   int n_cmp;
   int n_err;

   cpu_trace_emitter_if bus ();

   cpu_trace_emitter dut (
      .clk        (clk),
      .reset      (reset),
      .rec        (bus),
      .char       (ch),
      .char_valid (ch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one record from IDLE and release in_valid after the accepting edge
   task automatic send(input bit is_reg, input logic [15:0] t, input logic [31:0] pc,
                       input logic [31:0] addr, input logic [31:0] data);
      int b;
      @(negedge clk);
      bus.in_is_reg = is_reg;
      bus.in_time   = t;
      bus.in_pc     = pc;
      bus.in_addr   = addr;
      bus.in_data   = data;
      bus.in_valid  = 1'b1;
      b = 0;
      while (!bus.in_ready && b < 100) begin
         @(negedge clk);
         b++;
      end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // Gather characters from the first valid cycle until char_valid drops
   task automatic collect(input int max_cycles, output string s, output int wait_cyc,
                          output int ready_hi, output int ready_bad);
      int n;
      s = "";
      wait_cyc = 0;
      ready_hi = 0;
      ready_bad = 0;
      n = 0;
      @(negedge clk);
      while (!ch_valid && wait_cyc < max_cycles) begin
         wait_cyc++;
         @(negedge clk);
      end
      while (ch_valid && n < max_cycles) begin
         s = $sformatf("%s%c", s, ch);
         if (bus.in_ready) begin
            ready_hi++;
            if (ch != "#") ready_bad++;
         end
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #2;
      n_cmp++;
      if (ch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valid: char_valid=%b required 0", ch_valid);
      end
      n_cmp++;
      if (ch !== 8'h00) begin
         n_err++;
         $display("FAIL reset_char: char=%h required 00", ch);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready);
      end
      // A record offered while reset is high must be ignored
      bus.in_is_reg = 1'b1;
      bus.in_time   = 16'd1;
      bus.in_pc     = 32'h0;
      bus.in_addr   = 32'h1;
      bus.in_data   = 32'h0;
      bus.in_valid  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hs_ignored: char_valid=%b required 0", ch_valid);
      end
      bus.in_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ch_valid !== 1'b0 || ch !== 8'h00) begin
         n_err++;
         $display("FAIL reset_release: char_valid=%b char=%h required 0/00", ch_valid, ch);
      end
   endtask

   task automatic test_idle;
      int bad;
      bad = 0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ch_valid !== 1'b0 || ch !== 8'h00) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL idle_quiet: %0d active cycles required 0", bad);
      end
   endtask

   task automatic test_register_frame;
      string s;
      int w, rh, rb;
      send(1'b1, 16'd123, 32'h0000_3000, 32'd5, 32'h0000_abcd);
      collect(100, s, w, rh, rb);
      n_cmp++;
      if (s != "^123@00003000: $5 <= 0000abcd#") begin
         n_err++;
         $display("FAIL reg_frame: got \"%s\" required \"^123@00003000: $5 <= 0000abcd#\"", s);
      end
      n_cmp++;
      if (s.len() != 30) begin
         n_err++;
         $display("FAIL reg_frame_len: got %0d required 30", s.len());
      end
      n_cmp++;
      if (w != 0) begin
         n_err++;
         $display("FAIL reg_latency: '^' after %0d extra cycles required 0", w);
      end
      n_cmp++;
      if (rh != 1 || rb != 0) begin
         n_err++;
         $display("FAIL reg_ready: ready cycles %0d (non-END %0d) required 1 (0)", rh, rb);
      end
      n_cmp++;
      if (ch !== 8'h00 || bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reg_after: char=%h in_ready=%b required 00/1", ch, bus.in_ready);
      end
   endtask

   task automatic test_memory_frame;
      string s;
      int w, rh, rb;
      send(1'b0, 16'd0, 32'hdead_beef, 32'h0000_001c, 32'hffff_ffff);
      collect(100, s, w, rh, rb);
      n_cmp++;
      if (s != "^0@deadbeef: *0000001c <= ffffffff#") begin
         n_err++;
         $display("FAIL mem_frame: got \"%s\" required \"^0@deadbeef: *0000001c <= ffffffff#\"",
                  s);
      end
      n_cmp++;
      if (s.len() != 35) begin
         n_err++;
         $display("FAIL mem_frame_len: got %0d required 35", s.len());
      end
   endtask

   task automatic test_reg31;
      string s;
      int w, rh, rb;
      send(1'b1, 16'd7, 32'h1234_5678, 32'hffff_ffff, 32'h89ab_cdef);
      collect(100, s, w, rh, rb);
      n_cmp++;
      if (s != "^7@12345678: $31 <= 89abcdef#") begin
         n_err++;
         $display("FAIL reg31_frame: got \"%s\" required \"^7@12345678: $31 <= 89abcdef#\"", s);
      end
   endtask

   task automatic test_time_width;
      logic [15:0] tv [7] = '{16'd65535, 16'd10000, 16'd9999, 16'd10, 16'd1000, 16'd100, 16'd9};
      string ts [7] = '{"9999", "9999", "9999", "10", "1000", "100", "9"};
      string s, e;
      int w, rh, rb;
      for (int i = 0; i < 7; i++) begin
         send(1'b1, tv[i], 32'h0, 32'h0, 32'h0);
         collect(100, s, w, rh, rb);
         e = $sformatf("^%s@00000000: $0 <= 00000000#", ts[i]);
         n_cmp++;
         if (s != e) begin
            n_err++;
            $display("FAIL time_%0d: got \"%s\" required \"%s\"", tv[i], s, e);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit          isr [3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] tt  [3] = '{16'd1, 16'd42, 16'd9999};
      logic [31:0] pcs [3] = '{32'h0000_0010, 32'h0000_0014, 32'h0000_0018};
      logic [31:0] ads [3] = '{32'd1, 32'h8000_0000, 32'd10};
      logic [31:0] dts [3] = '{32'h0000_0001, 32'hcafe_f00d, 32'h0bad_c0de};
      string s, e;
      int w, rh, rb;
      e = {"^1@00000010: $1 <= 00000001#", "^42@00000014: *80000000 <= cafef00d#",
           "^9999@00000018: $10 <= 0badc0de#"};
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               int b;
               @(negedge clk);
               bus.in_is_reg = isr[k];
               bus.in_time   = tt[k];
               bus.in_pc     = pcs[k];
               bus.in_addr   = ads[k];
               bus.in_data   = dts[k];
               bus.in_valid  = 1'b1;
               b = 0;
               while (!bus.in_ready && b < 100) begin
                  @(negedge clk);
                  b++;
               end
               @(posedge clk);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
         end
         collect(200, s, w, rh, rb);
      join
      n_cmp++;
      if (s != e) begin
         n_err++;
         $display("FAIL b2b_stream: got \"%s\" required \"%s\"", s, e);
      end
      n_cmp++;
      if (rh != 3 || rb != 0) begin
         n_err++;
         $display("FAIL b2b_ready: ready cycles %0d (non-END %0d) required 3 (0)", rh, rb);
      end
      n_cmp++;
      if (ch !== 8'h00) begin
         n_err++;
         $display("FAIL b2b_after: char=%h required 00", ch);
      end
   endtask

   task automatic test_reset_mid_frame;
      string s;
      int w, rh, rb;
      send(1'b1, 16'd5, 32'h0123_4567, 32'd3, 32'h0000_0001);
      @(negedge clk);            // '^'
      repeat (7) @(negedge clk); // PC digit 4
      n_cmp++;
      if (ch !== "4" || ch_valid !== 1'b1) begin
         n_err++;
         $display("FAIL midframe_pc4: char=%h valid=%b required 34/1", ch, ch_valid);
      end
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if (ch_valid !== 1'b0 || ch !== 8'h00) begin
         n_err++;
         $display("FAIL midframe_async: char_valid=%b char=%h required 0/00", ch_valid, ch);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ch_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midframe_idle: char_valid=%b in_ready=%b required 0/1", ch_valid,
                  bus.in_ready);
      end
      send(1'b1, 16'd77, 32'ha5a5_a5a5, 32'd0, 32'h7654_3210);
      collect(100, s, w, rh, rb);
      n_cmp++;
      if (s != "^77@a5a5a5a5: $0 <= 76543210#") begin
         n_err++;
         $display("FAIL midframe_fresh: got \"%s\" required \"^77@a5a5a5a5: $0 <= 76543210#\"", s);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_is_reg = 1'b0;
      bus.in_time   = 16'd0;
      bus.in_pc     = 32'h0;
      bus.in_addr   = 32'h0;
      bus.in_data   = 32'h0;
      test_reset();
      test_idle();
      test_register_frame();
      test_memory_frame();
      test_reg31();
      test_time_width();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
